i2c_slave_fifo: RTL and testbench

Synthesizable I2C slave target with a 7-bit address and a loopback byte FIFO. Bytes written by an I2C master are stored in the FIFO, and I2C reads return them in order. It is the block directly downstream of the APB-to-I2C master bridge: it sits on the shared open-drain SDA/SCL bus and serves as the silicon counterpart of the bench's virtual I2C slave.

---
 rtl/i2c_slave_fifo.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_slave_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_fifo.sv
// I2C slave target with a 7-bit address and a loopback byte FIFO.
// Bytes written by the master are queued and returned in order on reads.
module i2c_slave_fifo #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         FIFO_DEPTH = 8,
  parameter bit         MSB_LSB    = 1'b1,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          sda_oe,
  output logic                          busy,
  output logic                          addressed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    s1, s2, f, fd;
  logic [FW-1:0] fcnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 2'b11;
      s2      <= 2'b11;
      f       <= 2'b11;
      fd      <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      s1 <= {sda_i, scl_i};
      s2 <= s1;
      fd <= f;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == f[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          f[i]    <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic scl_f, scl_d, sda_f, sda_d;
  logic start_ev, stop_ev, scl_rise, scl_fall, bus_ev;
  assign scl_f    = f[0];
  assign scl_d    = fd[0];
  assign sda_f    = f[1];
  assign sda_d    = fd[1];
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign bus_ev   = start_ev | stop_ev;

  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic       rw, ack_phase, ack_pend;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;

  logic [7:0] rx_byte, sr_shift, rd_byte;
  logic       last_bit, push, ovf_ev, load, pop;

  function automatic logic tx_bit(input logic [7:0] b);
    return MSB_LSB ? b[7] : b[0];
  endfunction

  assign rx_byte  = MSB_LSB ? {sr[6:0], sda_f} : {sda_f, sr[7:1]};
  assign sr_shift = MSB_LSB ? {sr[6:0], 1'b0} : {1'b0, sr[7:1]};
  assign last_bit = (bit_cnt == 3'd7);
  assign rd_byte  = fifo_empty ? FILL_BYTE : mem[rp];

  assign push   = (state == WR_DATA) && scl_rise && last_bit && !fifo_full && !bus_ev;
  assign ovf_ev = (state == WR_DATA) && scl_rise && last_bit && fifo_full && !bus_ev;
  // A read byte is fetched on the falling edge that ends an acknowledged 9th bit.
  assign load   = scl_fall && ack_phase && !bus_ev &&
                  (((state == ADDR_ACK) && rw) || (state == RD_ACK));
  assign pop    = load && !fifo_empty;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (push) begin
      wp    <= wp + AW'(1);
      count <= count + CW'(1);
    end else if (pop) begin
      rp    <= rp + AW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      ack_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_ev;
      underflow <= load && fifo_empty;
      if (stop_ev) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        addressed <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_ev) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
        addressed <= 1'b0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            sr      <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state     <= ADDR_ACK;
                addressed <= 1'b1;
                rw        <= rx_byte[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (rw) begin
                sr     <= rd_byte;
                sda_oe <= ~tx_bit(rd_byte);
                state  <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            sr      <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              ack_pend <= !fifo_full;
              state    <= WR_ACK;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= ack_pend;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              sda_oe    <= 1'b0;
              bit_cnt   <= '0;
              state     <= ack_pend ? WR_DATA : IGNORE;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (last_bit) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= RD_ACK;
            end else begin
              sr      <= sr_shift;
              sda_oe  <= ~tx_bit(sr_shift);
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_f) state <= IGNORE;
              else       ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              sr        <= rd_byte;
              sda_oe    <= ~tx_bit(rd_byte);
              bit_cnt   <= '0;
              state     <= RD_DATA;
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_fifo.sv
// Directed bench for i2c_slave_fifo: a bit-level I2C master drives the
// wired-AND bus and hand-computed expectations are asserted at each step.
module tb_i2c_slave_fifo;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, addressed, fifo_empty, fifo_full, overflow, underflow;
  logic [3:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;
  int ovf_n = 0, unf_n = 0, oe_n = 0, addr_n = 0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .addressed  (addressed),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (overflow)  ovf_n  <= ovf_n + 1;
    if (underflow) unf_n  <= unf_n + 1;
    if (sda_oe)    oe_n   <= oe_n + 1;
    if (addressed) addr_n <= addr_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_cyc(Q);
    r = sda_bus;
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic do_start;
    sda_m = 1'b1;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_cyc(Q);
    sda_m = 1'b0;
    wait_cyc(Q);
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic do_stop;
    sda_m = 1'b0;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_cyc(Q);
    sda_m = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~mack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         base_ovf, base_unf, base_oe, base_addr;

    // reset
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);

    // write three bytes
    do_start;
    check("wr_busy", busy, 1);
    send_byte(8'h34, ack);
    check("wr_addr_ack", ack, 1);
    check("wr_addressed", addressed, 1);
    send_byte(8'h01, ack);
    check("wr_ack1", ack, 1);
    send_byte(8'h02, ack);
    check("wr_ack2", ack, 1);
    send_byte(8'h03, ack);
    check("wr_ack3", ack, 1);
    do_stop;
    check("wr_count", fifo_count, 3);
    check("wr_busy_after_stop", busy, 0);
    check("wr_addressed_after_stop", addressed, 0);

    // read back
    do_start;
    send_byte(8'h35, ack);
    check("rd_addr_ack", ack, 1);
    read_byte(1'b1, d);
    check("rd_byte1", d, 8'h01);
    read_byte(1'b1, d);
    check("rd_byte2", d, 8'h02);
    read_byte(1'b0, d);
    check("rd_byte3", d, 8'h03);
    check("rd_release", sda_oe, 0);
    do_stop;
    check("rd_empty", fifo_empty, 1);
    check("rd_bus_high", sda_bus, 1);

    // overflow: nine writes into an 8-deep FIFO, pointers wrap
    base_ovf = ovf_n;
    do_start;
    send_byte(8'h34, ack);
    check("ov_addr_ack", ack, 1);
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'h10 + 8'(i), ack);
      check("ov_ack", ack, 1);
    end
    send_byte(8'h19, ack);
    check("ov_nack9", ack, 0);
    do_stop;
    check("ov_pulses", ovf_n - base_ovf, 1);
    check("ov_full", fifo_full, 1);
    check("ov_count", fifo_count, 8);

    do_start;
    send_byte(8'h35, ack);
    check("ovrd_addr_ack", ack, 1);
    for (int i = 1; i <= 8; i++) begin
      read_byte(i != 8, d);
      check("ovrd_byte", d, 8'h10 + 8'(i));
    end
    do_stop;
    check("ovrd_empty", fifo_empty, 1);

    // address mismatch
    base_oe   = oe_n;
    base_addr = addr_n;
    do_start;
    send_byte(8'h36, ack);
    check("mm_nack", ack, 0);
    do_stop;
    check("mm_oe_cycles", oe_n - base_oe, 0);
    check("mm_addressed_cycles", addr_n - base_addr, 0);
    check("mm_count", fifo_count, 0);

    // empty read, repeated START write, repeated START read with reset
    base_unf = unf_n;
    do_start;
    send_byte(8'h35, ack);
    check("er_addr_ack", ack, 1);
    read_byte(1'b0, d);
    check("er_fill", d, 8'hFF);
    check("er_underflow", unf_n - base_unf, 1);
    do_start;
    send_byte(8'h34, ack);
    check("rs_addr_ack", ack, 1);
    send_byte(8'hA5, ack);
    check("rs_data_ack", ack, 1);
    check("rs_count", fifo_count, 1);
    do_start;
    send_byte(8'h35, ack);
    check("mr_addr_ack", ack, 1);
    clock_bit(1'b1, r);
    check("mr_bit7", r, 1);
    sda_m = 1'b1;
    wait_cyc(2);
    check("mr_driving0", sda_oe, 1);
    rst = 1'b1;
    wait_cyc(1);
    check("mr_rst_oe", sda_oe, 0);
    check("mr_rst_busy", busy, 0);
    check("mr_rst_addressed", addressed, 0);
    check("mr_rst_count", fifo_count, 0);
    rst = 1'b0;
    wait_cyc(2);
    do_stop;
    check("mr_final_busy", busy, 0);
    check("mr_final_oe", sda_oe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
